// File: rtl/datapath_pkg.sv
// datapath_pkg
//   Shared definitions for the host-bound unpack path: lane and beat widths,
//   the unpack FSM state type, beat-select positions and a helper that forms
//   the first beat of a word.
//   Ports: none (package).
package datapath_pkg;

  localparam int LANE_W = 64;
  localparam int WORD_W = 3 * LANE_W;
  localparam int BEAT_W = 2 * LANE_W;
  localparam int SEQ_W  = 16;

  // Beat-select positions: beat0 carries the top lane of the word, beat1
  // carries the lower two lanes unchanged.
  localparam int BEAT0_SRC_LSB = 2 * LANE_W;
  localparam int BEAT1_SRC_MSB = BEAT_W - 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HI   = 2'd1,
    LO   = 2'd2
  } unpack_state_t;

  // beat0 = {word top lane, low lane}; the low lane is zero or a sequence tag
  function automatic logic [BEAT_W-1:0] make_beat0(input logic [WORD_W-1:0] word,
                                                   input logic [LANE_W-1:0] low_lane);
    return {word[WORD_W-1:BEAT0_SRC_LSB], low_lane};
  endfunction

endpackage

// File: rtl/datapath_unpack_fsm.sv
// datapath_unpack_fsm
//   Output side of the unpack FIFO: holds one 192-bit word and presents it as
//   two 128-bit beats under a valid/ready handshake. Raises 'load' whenever the
//   word at the storage read pointer is taken into the hold register.
//   Optional feature macro: DATAPATH_UNPACK_LAST_EN (adds out_last and a
//   16-bit word sequence tag in beat0's low lane).
//   Ports:
//     clk, rst   clock and synchronous active-high reset
//     empty      storage holds no words
//     rd_data    word at the storage read pointer
//     out_ready  consumer accepts the current beat
//     load       hold register takes rd_data this cycle (read pointer advances)
//     out_data   current beat
//     out_valid  beat available
//     out_last   (macro only) high with beat1
module datapath_unpack_fsm
  import datapath_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              empty,
  input  logic [WORD_W-1:0] rd_data,
  input  logic              out_ready,
  output logic              load,
  output logic [BEAT_W-1:0] out_data,
  output logic              out_valid
`ifdef DATAPATH_UNPACK_LAST_EN
  ,
  output logic              out_last
`endif
);

  unpack_state_t     state, state_next;
  logic [WORD_W-1:0] hold;
  logic [LANE_W-1:0] low_lane;

`ifdef DATAPATH_UNPACK_LAST_EN
  logic [SEQ_W-1:0] word_seq;
  logic [SEQ_W-1:0] hold_seq;

  // The tag is captured with the word so it stays stable across a stall;
  // the counter wraps naturally at 16 bits.
  always_ff @(posedge clk) begin
    if (rst) begin
      word_seq <= '0;
      hold_seq <= '0;
    end else if (load) begin
      word_seq <= word_seq + 1'b1;
      hold_seq <= word_seq;
    end
  end

  assign low_lane = {{(LANE_W-SEQ_W){1'b0}}, hold_seq};
  assign out_last = (state == LO);
`else
  assign low_lane = '0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      hold  <= '0;
    end else begin
      state <= state_next;
      if (load) hold <= rd_data;
    end
  end

  // Reloading straight out of LO keeps the beat stream gap-free when ready
  // stays high.
  always_comb begin
    state_next = state;
    load       = 1'b0;
    out_valid  = 1'b0;
    case (state)
      IDLE: begin
        if (!empty) begin
          load       = 1'b1;
          state_next = HI;
        end
      end
      HI: begin
        out_valid = 1'b1;
        if (out_ready) state_next = LO;
      end
      LO: begin
        out_valid = 1'b1;
        if (out_ready) begin
          if (!empty) begin
            load       = 1'b1;
            state_next = HI;
          end else begin
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    out_data = '0;
    case (state)
      HI:      out_data = make_beat0(hold, low_lane);
      LO:      out_data = hold[BEAT1_SRC_MSB:0];
      default: out_data = '0;
    endcase
  end

endmodule

// File: rtl/datapath_unpack_fifo.sv
// datapath_unpack_fifo
//   Host-bound return path: buffers 192-bit result words and emits each as two
//   128-bit beats (beat0 = {word[191:128], low lane}, beat1 = word[127:0]).
//   Owns the word storage, read/write pointers and status flags; the beat
//   sequencing lives in datapath_unpack_fsm.
//   Optional feature macro: DATAPATH_UNPACK_LAST_EN (adds out_last and a word
//   sequence tag in beat0's low lane).
//   Ports:
//     clk, rst   clock and synchronous active-high reset
//     wr         write request, accepted when !full
//     data_in    word to store
//     full       DEPTH words stored
//     threshold  at least DEPTH/2 words stored
//     overflow   sticky: write attempted while full, cleared by next load
//     out_data   current beat
//     out_valid  beat available
//     out_ready  consumer accepts
//     empty      storage holds no words
//     underflow  sticky: ready while no beat, cleared by next accepted write
//     out_last   (macro only) high with beat1
module datapath_unpack_fifo
  import datapath_pkg::*;
#(
  parameter int INPUT_DATA_WIDTH  = 192,
  parameter int OUTPUT_DATA_WIDTH = 128,
  parameter int DEPTH             = 1024,
  parameter int DEPTH_SIZE        = 10
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         wr,
  input  logic [INPUT_DATA_WIDTH-1:0]  data_in,
  output logic                         full,
  output logic                         threshold,
  output logic                         overflow,
  output logic [OUTPUT_DATA_WIDTH-1:0] out_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic                         empty,
  output logic                         underflow
`ifdef DATAPATH_UNPACK_LAST_EN
  ,
  output logic                         out_last
`endif
);

  logic [INPUT_DATA_WIDTH-1:0] mem [DEPTH];
  logic [DEPTH_SIZE:0]         w_ptr, r_ptr, diff;
  logic                        wr_en, load;

  // Flags come from the registered pointers only, so a same-cycle load never
  // frees a slot for a same-cycle write.
  assign full      = (w_ptr[DEPTH_SIZE] != r_ptr[DEPTH_SIZE]) &&
                     (w_ptr[DEPTH_SIZE-1:0] == r_ptr[DEPTH_SIZE-1:0]);
  assign empty     = (w_ptr == r_ptr);
  assign diff      = w_ptr - r_ptr;
  assign threshold = diff[DEPTH_SIZE] | diff[DEPTH_SIZE-1];
  assign wr_en     = wr && !full;

  // Storage array carries no reset; the pointers alone define its contents.
  always_ff @(posedge clk) begin
    if (wr_en) mem[w_ptr[DEPTH_SIZE-1:0]] <= data_in;
  end

  // Load clears overflow ahead of a new rejected write; an accepted write
  // clears underflow ahead of a new empty-side ready.
  always_ff @(posedge clk) begin
    if (rst) begin
      w_ptr     <= '0;
      r_ptr     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_en) w_ptr <= w_ptr + 1'b1;
      if (load)  r_ptr <= r_ptr + 1'b1;

      if (load)            overflow <= 1'b0;
      else if (wr && full) overflow <= 1'b1;

      if (wr_en)                        underflow <= 1'b0;
      else if (out_ready && !out_valid) underflow <= 1'b1;
    end
  end

  datapath_unpack_fsm u_fsm (
    .clk       (clk),
    .rst       (rst),
    .empty     (empty),
    .rd_data   (mem[r_ptr[DEPTH_SIZE-1:0]]),
    .out_ready (out_ready),
    .load      (load),
    .out_data  (out_data),
    .out_valid (out_valid)
`ifdef DATAPATH_UNPACK_LAST_EN
    ,
    .out_last  (out_last)
`endif
  );

endmodule

// File: tb/tb_datapath_unpack_fifo.sv
// tb_datapath_unpack_fifo
//   Self-checking bench for datapath_unpack_fifo. A queue-based model of the
//   stored words and the word currently being sent is compared against the
//   DUT on every falling edge; directed scenarios add literal expectations.
//   Honours DATAPATH_UNPACK_LAST_EN when defined.
module tb_datapath_unpack_fifo;

  localparam int DEPTH = 1024;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         wr = 1'b0;
  logic         out_ready = 1'b0;
  logic [191:0] data_in = '0;
  logic         full, threshold, overflow, out_valid, empty, underflow;
  logic [127:0] out_data;
`ifdef DATAPATH_UNPACK_LAST_EN
  logic         out_last;
`endif

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  datapath_unpack_fifo dut (
    .clk       (clk),
    .rst       (rst),
    .wr        (wr),
    .data_in   (data_in),
    .full      (full),
    .threshold (threshold),
    .overflow  (overflow),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .empty     (empty),
    .underflow (underflow)
`ifdef DATAPATH_UNPACK_LAST_EN
    ,
    .out_last  (out_last)
`endif
  );

  // Reference model: words waiting in storage, plus the word being sent and
  // which of its two beats is on the output.
  logic [191:0] m_q[$];
  logic [191:0] m_word = '0;
  bit           m_valid = 1'b0;
  int           m_beat = 0;
  bit           m_ovf = 1'b0;
  bit           m_udf = 1'b0;
  logic [15:0]  m_seq = '0;
  logic [15:0]  m_word_seq = '0;

  always @(posedge clk) begin
    bit pre_full, pre_empty, acc, ld, hs;
    if (rst) begin
      m_q.delete();
      m_valid = 1'b0;
      m_beat  = 0;
      m_ovf   = 1'b0;
      m_udf   = 1'b0;
      m_seq   = '0;
    end else begin
      pre_full  = (m_q.size() == DEPTH);
      pre_empty = (m_q.size() == 0);
      acc = wr && !pre_full;
      hs  = m_valid && out_ready;
      ld  = !pre_empty && (!m_valid || (hs && m_beat == 1));
      if (ld) m_ovf = 1'b0;
      else if (wr && pre_full) m_ovf = 1'b1;
      if (acc) m_udf = 1'b0;
      else if (out_ready && !m_valid) m_udf = 1'b1;
      if (hs && m_beat == 0) m_beat = 1;
      else if (hs && m_beat == 1) m_valid = 1'b0;
      if (ld) begin
        m_word     = m_q.pop_front();
        m_word_seq = m_seq;
        m_seq      = m_seq + 16'd1;
        m_valid    = 1'b1;
        m_beat     = 0;
      end
      if (acc) m_q.push_back(data_in);
    end
  end

  function automatic logic [191:0] exp_beat();
    logic [63:0] low = '0;
`ifdef DATAPATH_UNPACK_LAST_EN
    low = {48'h0, m_word_seq};
`endif
    if (m_beat == 0) return {64'h0, m_word[191:128], low};
    return {64'h0, m_word[127:0]};
  endfunction

  function automatic logic [191:0] rand_word();
    return {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic checkOutput(input string name, input logic [191:0] act, input logic [191:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input bit w, input logic [191:0] d, input bit rdy);
    @(negedge clk);
    wr        = w;
    data_in   = d;
    out_ready = rdy;
  endtask

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      checkOutput("out_valid", out_valid, m_valid);
      if (m_valid) checkOutput("out_data", out_data, exp_beat());
      checkOutput("full", full, m_q.size() == DEPTH);
      checkOutput("empty", empty, m_q.size() == 0);
      checkOutput("threshold", threshold, m_q.size() >= DEPTH / 2);
      checkOutput("overflow", overflow, m_ovf);
      checkOutput("underflow", underflow, m_udf);
`ifdef DATAPATH_UNPACK_LAST_EN
      checkOutput("out_last", out_last, m_valid && m_beat == 1);
`endif
    end
  end

  initial begin
    logic [191:0] word_a;
    int cnt;
    bit done;
    word_a = {64'h1111111111111111, 64'h2222222222222222, 64'h3333333333333333};

    // Reset state
    repeat (2) @(negedge clk);
    checkOutput("rst_empty", empty, 1'b1);
    checkOutput("rst_full", full, 1'b0);
    checkOutput("rst_threshold", threshold, 1'b0);
    checkOutput("rst_out_valid", out_valid, 1'b0);
    checkOutput("rst_out_data", out_data, '0);
    checkOutput("rst_overflow", overflow, 1'b0);
    checkOutput("rst_underflow", underflow, 1'b0);
    rst    = 1'b0;
    chk_en = 1'b1;

    // Single word, literal beats
    applyStimulus(1'b1, word_a, 1'b0);
    applyStimulus(1'b0, '0, 1'b0);
    checkOutput("a_no_valid_yet", out_valid, 1'b0);
    checkOutput("a_not_empty", empty, 1'b0);
    applyStimulus(1'b0, '0, 1'b1);
    checkOutput("a_valid", out_valid, 1'b1);
    checkOutput("a_beat0", out_data, {64'h0, 64'h1111111111111111, 64'h0});
    applyStimulus(1'b0, '0, 1'b1);
    checkOutput("a_beat1", out_data, {64'h0, 64'h2222222222222222, 64'h3333333333333333});
    applyStimulus(1'b0, '0, 1'b0);
    checkOutput("a_idle", out_valid, 1'b0);
    checkOutput("a_empty", empty, 1'b1);
    checkOutput("a_no_underflow", underflow, 1'b0);

    // Underflow set by ready while empty, cleared by a write
    applyStimulus(1'b0, '0, 1'b1);
    applyStimulus(1'b0, '0, 1'b0);
    checkOutput("udf_set", underflow, 1'b1);
    applyStimulus(1'b1, rand_word(), 1'b0);
    checkOutput("udf_held", underflow, 1'b1);
    applyStimulus(1'b0, '0, 1'b0);
    checkOutput("udf_cleared", underflow, 1'b0);

    // Reset while presenting beat0: no beat1 afterwards
    applyStimulus(1'b0, '0, 1'b0);
    checkOutput("hi_valid", out_valid, 1'b1);
    rst = 1'b1;
    applyStimulus(1'b0, '0, 1'b0);
    rst = 1'b0;
    checkOutput("rst_mid_valid", out_valid, 1'b0);
    checkOutput("rst_mid_empty", empty, 1'b1);
    applyStimulus(1'b0, '0, 1'b1);
    checkOutput("rst_mid_no_beat1", out_valid, 1'b0);
    applyStimulus(1'b0, '0, 1'b0);
    checkOutput("rst_mid_no_beat1b", out_valid, 1'b0);

    // Four words, ready held: eight beats with no bubble
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, rand_word(), 1'b0);
    applyStimulus(1'b0, '0, 1'b0);
    cnt = 0;
    for (int b = 0; b < 8; b++) begin
      applyStimulus(1'b0, '0, 1'b1);
      if (out_valid) cnt++;
    end
    checkOutput("burst_beats", cnt, 8);
    applyStimulus(1'b0, '0, 1'b0);
    checkOutput("burst_drop", out_valid, 1'b0);

    // Fill to full (one word sits in the hold register), then overflow
    for (int i = 1; i <= 1025; i++) begin
      applyStimulus(1'b1, rand_word(), 1'b0);
      if (i == 513) checkOutput("thr_511", threshold, 1'b0);
      if (i == 514) checkOutput("thr_512", threshold, 1'b1);
    end
    applyStimulus(1'b1, rand_word(), 1'b0);
    checkOutput("fill_full", full, 1'b1);
    checkOutput("fill_no_ovf", overflow, 1'b0);
    applyStimulus(1'b0, '0, 1'b1);
    checkOutput("ovf_set", overflow, 1'b1);
    checkOutput("ovf_full", full, 1'b1);
    applyStimulus(1'b0, '0, 1'b1);
    applyStimulus(1'b0, '0, 1'b1);
    checkOutput("ovf_cleared", overflow, 1'b0);
    checkOutput("full_cleared", full, 1'b0);
    done = 1'b0;
    for (int c = 0; c < 2300 && !done; c++) begin
      applyStimulus(1'b0, '0, 1'b1);
      done = (m_q.size() == 0) && !m_valid;
    end
    checkOutput("drain_done", done, 1'b1);
    applyStimulus(1'b0, '0, 1'b0);

`ifdef DATAPATH_UNPACK_LAST_EN
    // Sequence tags and out_last on three words
    rst = 1'b1;
    applyStimulus(1'b0, '0, 1'b0);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, rand_word(), 1'b0);
    applyStimulus(1'b0, '0, 1'b0);
    for (int b = 0; b < 6; b++) begin
      applyStimulus(1'b0, '0, 1'b1);
      checkOutput("last_flag", out_last, (b % 2) == 1);
      if ((b % 2) == 0) checkOutput("seq_lane", out_data[63:0], b / 2);
    end
    applyStimulus(1'b0, '0, 1'b0);
`endif

    // Randomized traffic with occasional resets
    for (int c = 0; c < 3000; c++) begin
      applyStimulus($urandom_range(0, 1) == 1, rand_word(), $urandom_range(0, 99) < 60);
      rst = ($urandom_range(0, 599) == 0);
    end
    rst = 1'b0;
    done = 1'b0;
    for (int c = 0; c < 2300 && !done; c++) begin
      applyStimulus(1'b0, '0, $urandom_range(0, 3) != 0);
      done = (m_q.size() == 0) && !m_valid;
    end
    checkOutput("final_drain_done", done, 1'b1);
    applyStimulus(1'b0, '0, 1'b0);
    @(negedge clk);
    chk_en = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
